// File: rtl/opl_pkg.sv
// Shared types and constants for the operand latch: FSM states, width codes,
// reset values and the width-to-byte-count decode.
package opl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0]  W_ADDR = 2'b00;
  localparam logic [1:0]  W_8    = 2'b01;
  localparam logic [1:0]  W_16   = 2'b10;
  localparam logic [1:0]  W_24   = 2'b11;

  localparam logic [7:0]  BYTE_RST = 8'h00;
  localparam logic [23:0] OPND_RST = 24'h00_0000;

  // Index of the last operand byte (n-1); width 00 follows the address bus size.
  function automatic logic [1:0] last_index(input logic [1:0] width, input logic ab24);
    case (width)
      W_8:     last_index = 2'd0;
      W_16:    last_index = 2'd1;
      W_24:    last_index = 2'd2;
      default: last_index = ab24 ? 2'd2 : 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/opl_shift.sv
// Data-bus history: DI is the live bus byte (or the held copy during a stall),
// DR and D3 are the two preceding accepted bytes.
module opl_shift
  import opl_pkg::*;
(
  input  logic       clk,
  input  logic       RST,
  input  logic       rdy,
  input  logic [7:0] DB,
  output logic [7:0] DI,
  output logic [7:0] DR,
  output logic [7:0] D3
);

  logic [7:0] di_hold;

  assign DI = rdy ? DB : di_hold;

  always_ff @(posedge clk) begin
    if (RST) begin
      di_hold <= BYTE_RST;
      DR      <= BYTE_RST;
      D3      <= BYTE_RST;
    end else if (rdy) begin
      di_hold <= DB;
      DR      <= DI;
      D3      <= DR;
    end
  end

endmodule

// File: rtl/operand_latch.sv
// Fetches a 1/2/3-byte little-endian operand from the memory bus and presents
// it on OPND with a one-cycle done pulse. Sign extension via OPERAND_LATCH_SEXT_EN.
module operand_latch
  import opl_pkg::*;
(
  input  logic        clk,
  input  logic        RST,
  input  logic [7:0]  DB,
  input  logic        rdy,
  input  logic        start,
  input  logic [1:0]  width,
  input  logic        ABWDTH,
`ifdef OPERAND_LATCH_SEXT_EN
  input  logic        sext,
`endif
  output logic [7:0]  DI,
  output logic [7:0]  DR,
  output logic [7:0]  D3,
  output logic [23:0] OPND,
  output logic        busy,
  output logic        done,
  output state_t      fsm_state
);

  // Flow control: a bus byte is taken only on a cycle with rdy=1; rdy=0 freezes
  // capture and counting. start is a level accepted only in IDLE, never queued.
  state_t     state, next_state;
  logic [1:0] cnt;
  logic [1:0] last;
  logic [7:0] b0, b1;
  logic       accept;
  logic [7:0] ext;
  logic [23:0] opnd_next;

  opl_shift u_shift (
    .clk (clk),
    .RST (RST),
    .rdy (rdy),
    .DB  (DB),
    .DI  (DI),
    .DR  (DR),
    .D3  (D3)
  );

`ifdef OPERAND_LATCH_SEXT_EN
  logic sext_q;
  assign ext = {8{sext_q & DB[7]}};
`else
  assign ext = 8'h00;
`endif

  assign accept    = (state == FETCH) && rdy;
  assign busy      = (state == FETCH);
  assign done      = (state == DONE);
  assign fsm_state = state;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = FETCH;
      FETCH:   if (rdy && (cnt == last)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The final byte arrives straight from the bus and tops the operand.
  always_comb begin
    opnd_next = OPND_RST;
    case (last)
      2'd0:    opnd_next = {ext, ext, DB};
      2'd1:    opnd_next = {ext, DB, b0};
      default: opnd_next = {DB, b1, b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= 2'd0;
      last  <= 2'd0;
      b0    <= BYTE_RST;
      b1    <= BYTE_RST;
      OPND  <= OPND_RST;
`ifdef OPERAND_LATCH_SEXT_EN
      sext_q <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if ((state == IDLE) && start) begin
        cnt  <= 2'd0;
        last <= last_index(width, ABWDTH);
`ifdef OPERAND_LATCH_SEXT_EN
        sext_q <= sext;
`endif
      end
      if (accept) begin
        case (cnt)
          2'd0:    b0 <= DB;
          2'd1:    b1 <= DB;
          default: ;
        endcase
        cnt <= cnt + 2'd1;
        if (cnt == last) OPND <= opnd_next;
      end
    end
  end

endmodule

// File: tb/tb_operand_latch.sv
// Directed bench for operand_latch: table-driven fetches plus hand-written
// reset, ignored-start and reset-mid-fetch sequences.
module tb_operand_latch;
  import opl_pkg::*;

  logic        clk = 1'b0;
  logic        RST, rdy, start, ABWDTH;
  logic [7:0]  DB;
  logic [1:0]  width;
`ifdef OPERAND_LATCH_SEXT_EN
  logic        sext;
`endif
  logic [7:0]  DI, DR, D3;
  logic [23:0] OPND;
  logic        busy, done;
  state_t      fsm_state;

  int checks = 0;
  int failures = 0;
  logic [23:0] exp_q[$];
  logic [23:0] last_opnd = 24'h0;

  operand_latch dut (
    .clk       (clk),
    .RST       (RST),
    .DB        (DB),
    .rdy       (rdy),
    .start     (start),
    .width     (width),
    .ABWDTH    (ABWDTH),
`ifdef OPERAND_LATCH_SEXT_EN
    .sext      (sext),
`endif
    .DI        (DI),
    .DR        (DR),
    .D3        (D3),
    .OPND      (OPND),
    .busy      (busy),
    .done      (done),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  w;
    logic        abw;
    logic        sx;
    logic [23:0] bus;    // byte k at bus[8k+:8]
    int          n;
    int          stalls; // rdy=0 cycles between byte 0 and byte 1
    logic [23:0] opnd;
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v);
    int  k, stall_left, cyc;
    bit  seen;
    logic [23:0] exp_opnd;
    exp_q.push_back(v.opnd);
    @(negedge clk);
    start = 1'b1; width = v.w; ABWDTH = v.abw; rdy = 1'b1; DB = 8'h00;
`ifdef OPERAND_LATCH_SEXT_EN
    sext = v.sx;
`endif
    #1 chk("idle_busy", busy, 0);
    k = 0; stall_left = v.stalls; seen = 0;
    for (cyc = 1; cyc <= 12 && !seen; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      ABWDTH = ~v.abw;
      if (k == 1 && stall_left > 0) begin
        rdy = 1'b0; DB = 8'($urandom_range(0, 255)); stall_left--;
        #1;
        chk("stall_di", DI, v.bus[7:0]);
        chk("stall_opnd", OPND, last_opnd);
      end else begin
        rdy = 1'b1;
        if (k < v.n) begin
          DB = v.bus[8*k +: 8];
          #1;
          chk("di_live", DI, v.bus[8*k +: 8]);
          if (k >= 1) chk("dr", DR, v.bus[8*(k-1) +: 8]);
          if (k >= 2) chk("d3", D3, v.bus[8*(k-2) +: 8]);
          if (cyc == 1) chk("fetch_busy", busy, 1);
          k++;
        end else begin
          DB = 8'($urandom_range(0, 255));
          #1;
        end
      end
      if (done) begin
        seen = 1;
        exp_opnd = exp_q.pop_front();
        chk("latency", cyc, v.n + 1 + v.stalls);
        chk("opnd", OPND, exp_opnd);
        chk("done_busy", busy, 0);
        last_opnd = exp_opnd;
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL done_timeout: got no done expected done within 12 cycles");
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    rdy = 1'b1; DB = 8'h00;
    #1;
    chk("done_pulse", done, 0);
    chk("opnd_hold", OPND, last_opnd);
  endtask

  initial begin
    bit saw_done;
    RST = 1'b1; rdy = 1'b1; start = 1'b1; DB = 8'hFF; width = W_24; ABWDTH = 1'b1;
`ifdef OPERAND_LATCH_SEXT_EN
    sext = 1'b0;
`endif

    // Reset: RST overrides rdy and start
    repeat (2) @(negedge clk);
    rdy = 1'b0;
    #1;
    chk("rst_di", DI, 0);
    chk("rst_dr", DR, 0);
    chk("rst_d3", D3, 0);
    chk("rst_opnd", OPND, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    RST = 1'b0; start = 1'b0;

    vecs.push_back('{w: W_24,   abw: 1'b0, sx: 1'b0, bus: 24'h563412, n: 3, stalls: 0, opnd: 24'h563412});
    vecs.push_back('{w: W_ADDR, abw: 1'b0, sx: 1'b0, bus: 24'h00ABCD, n: 2, stalls: 0, opnd: 24'h00ABCD});
    vecs.push_back('{w: W_ADDR, abw: 1'b1, sx: 1'b0, bus: 24'h030201, n: 3, stalls: 0, opnd: 24'h030201});
    vecs.push_back('{w: W_8,    abw: 1'b1, sx: 1'b0, bus: 24'h0000A5, n: 1, stalls: 0, opnd: 24'h0000A5});
    vecs.push_back('{w: W_16,   abw: 1'b0, sx: 1'b0, bus: 24'h002211, n: 2, stalls: 2, opnd: 24'h002211});
    vecs.push_back('{w: W_24,   abw: 1'b0, sx: 1'b0, bus: 24'h9A7FE1, n: 3, stalls: 1, opnd: 24'h9A7FE1});
    vecs.push_back('{w: W_8,    abw: 1'b0, sx: 1'b0, bus: 24'h000080, n: 1, stalls: 0, opnd: 24'h000080});
`ifdef OPERAND_LATCH_SEXT_EN
    vecs.push_back('{w: W_8,    abw: 1'b0, sx: 1'b1, bus: 24'h000080, n: 1, stalls: 0, opnd: 24'hFFFF80});
    vecs.push_back('{w: W_16,   abw: 1'b0, sx: 1'b1, bus: 24'h009234, n: 2, stalls: 0, opnd: 24'hFF9234});
    vecs.push_back('{w: W_16,   abw: 1'b0, sx: 1'b1, bus: 24'h007F34, n: 2, stalls: 0, opnd: 24'h007F34});
    vecs.push_back('{w: W_8,    abw: 1'b0, sx: 1'b0, bus: 24'h000080, n: 1, stalls: 0, opnd: 24'h000080});
`endif

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // start held high through FETCH and DONE must not restart the fetch
    @(negedge clk);
    start = 1'b1; width = W_16; ABWDTH = 1'b0; rdy = 1'b1; DB = 8'h00;
    @(negedge clk);
    DB = 8'h5A;
    #1 chk("ign_busy", busy, 1);
    @(negedge clk);
    DB = 8'hC3;
    @(negedge clk);
    DB = 8'h00;
    #1;
    chk("ign_done", done, 1);
    chk("ign_opnd", OPND, 24'h00C35A);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("ign_idle_busy", busy, 0);
    chk("ign_idle_done", done, 0);
    @(negedge clk);
    #1 chk("ign_idle_busy2", busy, 0);

    // Reset after the first byte: partial operand discarded, no done
    @(negedge clk);
    start = 1'b1; width = W_24; rdy = 1'b1; DB = 8'h00;
    @(negedge clk);
    start = 1'b0; DB = 8'h77;
    @(negedge clk);
    RST = 1'b1; start = 1'b1; DB = 8'h88;
    @(negedge clk);
    RST = 1'b0; start = 1'b0; rdy = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_opnd", OPND, 0);
    chk("mrst_di", DI, 0);
    chk("mrst_dr", DR, 0);
    chk("mrst_d3", D3, 0);
    saw_done = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rdy = 1'b1; DB = 8'($urandom_range(0, 255));
      #1 if (done || busy) saw_done = 1;
    end
    chk("mrst_no_done", saw_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
